spi_ram_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters: the SPI slave command stream (rx_valid/rx_data in, tx_valid/tx_data out) and a local parallel host port.
- Decodes SPI 10-bit commands, holds per-requester address state and buffers one pending SPI access.
- Arbitrates each RAM cycle round-robin and routes read data back to whichever requester issued the read.
- Sits between the SPI slave and the RAM in the SPI wrapper.

---
 rtl/spi_ram_pkg.sv | 24 ++
 rtl/spi_cmd_decoder.sv | 56 +++++
 rtl/spi_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_spi_ram_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI/host RAM arbiter: SPI opcodes, requester identity
// and the read-return tag carried alongside each RAM read.
package spi_ram_pkg;

  localparam int RAM_DATA_W = 8;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic {
    REQ_SPI  = 1'b0,
    REQ_HOST = 1'b1
  } req_e;

  typedef struct packed {
    logic valid;
    req_e req;
  } rd_tag_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: keeps the write/read address registers and a one-deep
// buffer holding the next SPI RAM access, flagging commands that find it full.
module spi_cmd_decoder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_data,
  input  logic                  spi_gnt,
  output logic                  pend,
  output logic                  pend_we,
  output logic [ADDR_W-1:0]     pend_addr,
  output logic [RAM_DATA_W-1:0] pend_wdata,
  output logic                  spi_ovr
);

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  spi_cmd_e          cmd;
  logic              post;
  logic              can_post;

  assign cmd      = spi_cmd_e'(rx_data[9:8]);
  assign post     = rx_valid && ((cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA));
  // A grant in this cycle frees the slot, so a same-cycle command takes it.
  assign can_post = !pend || spi_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      spi_ovr    <= 1'b0;
    end else begin
      spi_ovr <= 1'b0;
      if (rx_valid && (cmd == CMD_WR_ADDR)) wr_addr <= rx_data[ADDR_W-1:0];
      if (rx_valid && (cmd == CMD_RD_ADDR)) rd_addr <= rx_data[ADDR_W-1:0];
      if (post && can_post) begin
        pend       <= 1'b1;
        pend_we    <= (cmd == CMD_WR_DATA);
        pend_addr  <= (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
        pend_wdata <= rx_data[7:0];
      end else begin
        if (spi_gnt) pend <= 1'b0;
        if (post) spi_ovr <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM between the SPI command
// stream and a parallel host port. Optional macro: SPI_RAM_ARB_STATS_EN.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_data,
  output logic                  tx_valid,
  output logic [RAM_DATA_W-1:0] tx_data,
  output logic                  spi_ovr,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [RAM_DATA_W-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [RAM_DATA_W-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wdata,
  input  logic [RAM_DATA_W-1:0] ram_rdata
`ifdef SPI_RAM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]      conflict_cnt
`endif
);

  logic                  pend;
  logic                  pend_we;
  logic [ADDR_W-1:0]     pend_addr;
  logic [RAM_DATA_W-1:0] pend_wdata;
  logic                  spi_win;
  logic                  host_win;
  req_e                  last_grant;
  rd_tag_t               tag_issue;
  rd_tag_t               tag_data;

  spi_cmd_decoder #(
    .ADDR_W(ADDR_W)
  ) u_decoder (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .spi_gnt   (spi_win),
    .pend      (pend),
    .pend_we   (pend_we),
    .pend_addr (pend_addr),
    .pend_wdata(pend_wdata),
    .spi_ovr   (spi_ovr)
  );

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    host_win = 1'b0;
    spi_win  = 1'b0;
    if (host_req && (!pend || (last_grant == REQ_SPI))) host_win = 1'b1;
    else if (pend) spi_win = 1'b1;
  end

  assign host_gnt = host_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      last_grant <= REQ_HOST;
    end else begin
      ram_en <= spi_win || host_win;
      ram_we <= 1'b0;
      if (host_win) begin
        ram_we     <= host_we;
        ram_addr   <= host_addr;
        ram_wdata  <= host_wdata;
        last_grant <= REQ_HOST;
      end else if (spi_win) begin
        ram_we     <= pend_we;
        ram_addr   <= pend_addr;
        ram_wdata  <= pend_wdata;
        last_grant <= REQ_SPI;
      end
    end
  end

  // Two-stage tag pipe: tag_data lines up with the cycle ram_rdata is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_issue   <= '0;
      tag_data    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      tag_issue.valid <= (host_win && !host_we) || (spi_win && !pend_we);
      tag_issue.req   <= host_win ? REQ_HOST : REQ_SPI;
      tag_data        <= tag_issue;
      tx_valid        <= tag_data.valid && (tag_data.req == REQ_SPI);
      host_rvalid     <= tag_data.valid && (tag_data.req == REQ_HOST);
      if (tag_data.valid && (tag_data.req == REQ_SPI))  tx_data    <= ram_rdata;
      if (tag_data.valid && (tag_data.req == REQ_HOST)) host_rdata <= ram_rdata;
    end
  end

`ifdef SPI_RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (pend && host_req && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed and randomized bench for spi_ram_arbiter with a behavioural RAM and
// a per-requester expected-read scoreboard.
module tb_spi_ram_arbiter;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              rx_valid;
  logic [9:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              spi_ovr;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [7:0]        host_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata = 8'h00;
`ifdef SPI_RAM_ARB_STATS_EN
  logic [CNT_W-1:0]  conflict_cnt;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  logic [7:0] ram_mem   [256];
  logic [7:0] model_mem [256];
  bit         known     [256];
  logic [7:0] spi_exp[$];
  logic [7:0] host_exp[$];

  always #5 clk = ~clk;

  spi_ram_arbiter #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .spi_ovr    (spi_ovr),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef SPI_RAM_ARB_STATS_EN
    ,
    .conflict_cnt(conflict_cnt)
`endif
  );

  // Single-port synchronous RAM seen by the arbiter.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [9:0] cmd);
    rx_valid = 1'b1;
    rx_data  = cmd;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [63:0] out_vec();
    return {27'd0, tx_valid, spi_ovr, host_rvalid, ram_en, ram_we,
            tx_data, host_rdata, ram_addr, ram_wdata};
  endfunction

  // Scoreboard for the randomized phase.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid) begin
        check_output("tx_expected", 64'(spi_exp.size() != 0), 64'd1);
        if (spi_exp.size() != 0) check_output("spi_rd_data", 64'(tx_data), 64'(spi_exp.pop_front()));
      end
      if (host_rvalid) begin
        check_output("host_rvalid_expected", 64'(host_exp.size() != 0), 64'd1);
        if (host_exp.size() != 0) check_output("host_rd_data", 64'(host_rdata), 64'(host_exp.pop_front()));
      end
      if (spi_ovr) check_output("rand_no_ovr", 64'(spi_ovr), 64'd0);
    end
  end

  task automatic spi_random();
    logic [7:0] addr;
    logic [7:0] data;
    for (int n = 0; n < 40; n++) begin
      addr = 8'($urandom_range(0, 127));
      data = 8'($urandom);
      if (!known[addr] || ($urandom_range(0, 1) == 0)) begin
        apply_stimulus({2'b00, addr});
        apply_stimulus({2'b01, data});
        model_mem[addr] = data;
        known[addr]     = 1'b1;
      end else begin
        apply_stimulus({2'b10, addr});
        apply_stimulus({2'b11, data});
        spi_exp.push_back(model_mem[addr]);
      end
      repeat ($urandom_range(3, 6)) tick();
    end
  endtask

  task automatic host_random();
    logic [7:0] addr;
    logic [7:0] data;
    logic       we;
    int         waits;
    for (int n = 0; n < 40; n++) begin
      addr = 8'($urandom_range(128, 255));
      data = 8'($urandom);
      we   = !known[addr] || ($urandom_range(0, 1) == 0);
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
      #1;
      waits = 0;
      while (!host_gnt && waits < 4) begin
        @(posedge clk);
        #2;
        waits++;
      end
      check_output("host_wait_bound", 64'(waits <= 1), 64'd1);
      if (host_gnt) begin
        if (we) begin
          model_mem[addr] = data;
          known[addr]     = 1'b1;
        end else begin
          host_exp.push_back(model_mem[addr]);
        end
        tick();
      end
      host_req = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tx_seen, hr_seen, tx_cyc, hr_cyc;
    logic [7:0] tx_val, hr_val;
    bit any_out;
    rx_valid = 1'b0; rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check_output("reset_outs", out_vec(), 64'd0);
    rst_n = 1'b1;
    tick();

    // SPI write path
    apply_stimulus(10'h005);
    apply_stimulus(10'h1A5);
    tick();
    check_output("spi_wr_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h05, 8'hA5}));
    any_out = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) check_output("spi_wr_single", 64'(ram_en), 64'd0);
      any_out |= tx_valid;
    end
    check_output("spi_wr_no_tx", 64'(any_out), 64'd0);

    // SPI read path, 3 cycles after grant
    apply_stimulus(10'h205);
    apply_stimulus(10'h300);
    tick();
    check_output("spi_rd_ram", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, 8'h05}));
    check_output("spi_rd_lat1", 64'(tx_valid), 64'd0);
    tick();
    check_output("spi_rd_lat2", 64'(tx_valid), 64'd0);
    tick();
    check_output("spi_rd_valid", 64'({tx_valid, tx_data}), 64'({1'b1, 8'hA5}));
    tick();
    check_output("spi_rd_pulse", 64'(tx_valid), 64'd0);

    // Conflict after reset: SPI first
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    apply_stimulus(10'h210);
    rx_valid = 1'b1; rx_data = 10'h300;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h5A;
    #1;
    check_output("conflict1_host_wait", 64'(host_gnt), 64'd0);
    tick();
    check_output("conflict1_spi_ram", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, 8'h10}));
    check_output("conflict1_host_gnt", 64'(host_gnt), 64'd1);
    tick();
    host_req = 1'b0;
    check_output("conflict1_host_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h20, 8'h5A}));
    repeat (4) tick();

    // SPI-only grant, then a repeated conflict: host first
    apply_stimulus(10'h030);
    apply_stimulus(10'h1EE);
    tick();
    apply_stimulus(10'h210);
    rx_valid = 1'b1; rx_data = 10'h300;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h6B;
    #1;
    check_output("conflict2_host_gnt", 64'(host_gnt), 64'd1);
    tick();
    host_req = 1'b0;
    check_output("conflict2_host_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h20, 8'h6B}));
    tick();
    check_output("conflict2_spi_ram", 64'({ram_en, ram_we, ram_addr}), 64'({2'b10, 8'h10}));
    repeat (4) tick();

    // Overrun while the host holds the RAM
    apply_stimulus(10'h050);
    rx_valid = 1'b1; rx_data = 10'h111;
    tick();
    rx_data = 10'h122;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h77;
    #1;
    check_output("ovr_host_gnt", 64'(host_gnt), 64'd1);
    tick();
    rx_valid = 1'b0; host_req = 1'b0;
    check_output("ovr_pulse", 64'(spi_ovr), 64'd1);
    check_output("ovr_host_ram", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h40, 8'h77}));
    tick();
    check_output("ovr_pulse_end", 64'(spi_ovr), 64'd0);
    check_output("ovr_first_write", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({2'b11, 8'h50, 8'h11}));
    tick();
    check_output("ovr_second_dropped", 64'(ram_en), 64'd0);
    repeat (3) tick();

    // Alternating host/SPI reads are routed to their own requester
    apply_stimulus(10'h060);
    apply_stimulus(10'h1C3);
    tick(); tick();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h61; host_wdata = 8'h3C;
    tick();
    host_req = 1'b0;
    repeat (3) tick();
    apply_stimulus(10'h260);
    rx_valid = 1'b1; rx_data = 10'h300;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h61;
    tx_seen = 0; hr_seen = 0; tx_cyc = 0; hr_cyc = 0; tx_val = '0; hr_val = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin rx_valid = 1'b0; host_req = 1'b0; end
      if (tx_valid) begin tx_seen++; tx_cyc = k; tx_val = tx_data; end
      if (host_rvalid) begin hr_seen++; hr_cyc = k; hr_val = host_rdata; end
    end
    check_output("alt_host_route", 64'({hr_seen[7:0], hr_cyc[7:0], hr_val}), 64'({8'd1, 8'd3, 8'h3C}));
    check_output("alt_spi_route", 64'({tx_seen[7:0], tx_cyc[7:0], tx_val}), 64'({8'd1, 8'd4, 8'hC3}));

    // Reset one cycle after a read grant
    apply_stimulus(10'h260);
    apply_stimulus(10'h300);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_outs", out_vec(), 64'd0);
    tick();
    rst_n = 1'b1;
    any_out = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      any_out |= tx_valid | host_rvalid;
    end
    check_output("reset_kills_read", 64'(any_out), 64'd0);

    // Randomized concurrent traffic against the reference model
    mon_en = 1'b1;
    fork
      spi_random();
      host_random();
    join
    repeat (8) tick();
    mon_en = 1'b0;
    check_output("spi_exp_drained", 64'(spi_exp.size()), 64'd0);
    check_output("host_exp_drained", 64'(host_exp.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
